// File: rtl/tm1638_arb_pkg.sv
// Shared types and helpers for the TM1638 display arbiter.
package tm1638_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tm1638_display_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest candidate at or above ptr, else lowest overall.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    input  logic [N_REQ-1:0]         excl_i,
    output logic [N_REQ-1:0]         pick_o,
    output logic                     any_o
);

    logic [N_REQ-1:0] cand_s;
    logic [N_REQ-1:0] hi_mask_s;
    logic [N_REQ-1:0] upper_s;
    logic [N_REQ-1:0] src_s;

    // Split candidates into the at-or-above-ptr window and fall back to the full set.
    always_comb begin
        cand_s = req_i & ~excl_i;
        hi_mask_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask_s[i] = (i >= int'(ptr_i));
        end
        upper_s = cand_s & hi_mask_s;
        src_s   = (|upper_s) ? upper_s : cand_s;
    end

    assign pick_o = src_s & (~src_s + {{(N_REQ-1){1'b0}}, 1'b1});
    assign any_o  = |cand_s;

endmodule

// File: rtl/tm1638_display_arbiter.sv
// Round-robin owner selection with minimum dwell for the shared 8-digit TM1638 display.
module tm1638_display_arbiter
    import tm1638_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int W_DIGIT      = 8,
    parameter int DWELL_CYCLES = 27_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*W_DIGIT*4-1:0]   number_in,
    input  logic [N_REQ*W_DIGIT-1:0]     dots_in,
    input  logic                         hold,
    output logic [N_REQ-1:0]             grant,
    output logic                         grant_valid,
    output logic [W_DIGIT*4-1:0]         number_out,
    output logic [W_DIGIT-1:0]           dots_out,
    output logic                         blank
);

    localparam int NW = W_DIGIT * 4;
    localparam int PW = $clog2(N_REQ);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NW-1:0]    number_q, number_d;
    logic [W_DIGIT-1:0] dots_q, dots_d;
    logic             blank_q, blank_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] excl_s;
    logic [N_REQ-1:0] pick_s;
    logic             any_s;
    logic [2:0]       pick_idx_s;
    logic [PW-1:0]    next_ptr_s;
    logic             owner_req_s;

    // While showing, the current owner never competes for the next pick.
    assign excl_s = (state_q == ST_SHOW) ? grant_q : '0;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .excl_i (excl_s),
        .pick_o (pick_s),
        .any_o  (any_s)
    );

    assign pick_idx_s  = onehot_to_idx(8'(pick_s));
    assign next_ptr_s  = (pick_idx_s == 3'(N_REQ - 1)) ? '0 : PW'(pick_idx_s + 3'd1);
    assign owner_req_s = |(req & grant_q);

    // State, grant, dwell counter and pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            number_q <= '0;
            dots_q   <= '0;
            blank_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            number_q <= number_d;
            dots_q   <= dots_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state: grant from idle, release on owner drop, rotate after the dwell expires.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_SHOW;
                    grant_d = pick_s;
                    cnt_d   = '0;
                    ptr_d   = next_ptr_s;
                end else begin
                    grant_d = '0;
                end
            end
            ST_SHOW: begin
                if (!owner_req_s) begin
                    if (any_s) begin
                        grant_d = pick_s;
                        cnt_d   = '0;
                        ptr_d   = next_ptr_s;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else if ((cnt_q == CNT_MAX) && !hold && any_s) begin
                    grant_d = pick_s;
                    cnt_d   = '0;
                    ptr_d   = next_ptr_s;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Output data follows the next owner so new data lands on the same edge as the grant.
    always_comb begin
        number_d = '0;
        dots_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            number_d = number_d | (number_in[i*NW +: NW] & {NW{grant_d[i]}});
            dots_d   = dots_d | (dots_in[i*W_DIGIT +: W_DIGIT] & {W_DIGIT{grant_d[i]}});
        end
        blank_d = (state_d == ST_IDLE);
        valid_d = |grant_d;
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign number_out  = number_q;
    assign dots_out    = dots_q;
    assign blank       = blank_q;

endmodule
